// File: rtl/cpu_wb_bus_if_if.sv
// Wishbone master signal bundle for cpu_wb_bus_if. Master drives the
// request side and receives ack/read data; the slave modport mirrors it.
interface cpu_wb_bus_if_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;
   logic [31:0] wb_dat_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
      input  wb_ack_i, wb_dat_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
      output wb_ack_i, wb_dat_i
   );
endinterface

// File: rtl/cpu_wb_bus_if.sv
// CPU-to-Wishbone bridge: one outstanding access, stall handshake with ctrl.
// Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module cpu_wb_bus_if (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   input  logic        cpu_ce_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_we_i,
   input  logic [3:0]  cpu_sel_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   cpu_wb_bus_if_if.master wb
);

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      BUSY           = 2'd1,
      WAIT_FOR_STALL = 2'd2
   } state_t;

   state_t      state_r;
   logic [31:0] rd_buf_r;
   logic        bus_err_r;
   logic        timeout_s;
   logic [31:0] cpu_data_s;
   logic        stallreq_s;

`ifdef WB_TIMEOUT_EN
   logic [7:0] tmo_cnt_r;

   // The 255th unacknowledged BUSY cycle is the one that gives up.
   assign timeout_s = (state_r == BUSY) && !wb.wb_ack_i && !flush_i &&
                      (tmo_cnt_r == 8'd254);

   // Unacknowledged BUSY cycle counter; cleared whenever BUSY is left.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= 8'd0;
      end else if ((state_r == BUSY) && !wb.wb_ack_i && !flush_i && !timeout_s) begin
         tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
         tmo_cnt_r <= 8'd0;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Access FSM with registered Wishbone outputs and read buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         rd_buf_r    <= 32'd0;
         bus_err_r   <= 1'b0;
         wb.wb_adr_o <= 32'd0;
         wb.wb_dat_o <= 32'd0;
         wb.wb_sel_o <= 4'd0;
         wb.wb_we_o  <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_cyc_o <= 1'b0;
      end else begin
         bus_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cpu_ce_i && !flush_i) begin
                  wb.wb_adr_o <= cpu_addr_i;
                  wb.wb_dat_o <= cpu_data_i;
                  wb.wb_we_o  <= cpu_we_i;
                  wb.wb_sel_o <= cpu_sel_i;
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_cyc_o <= 1'b1;
                  rd_buf_r    <= 32'd0;
                  state_r     <= BUSY;
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               if (flush_i || wb.wb_ack_i || timeout_s) begin
                  wb.wb_adr_o <= 32'd0;
                  wb.wb_dat_o <= 32'd0;
                  wb.wb_sel_o <= 4'd0;
                  wb.wb_we_o  <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_cyc_o <= 1'b0;
               end else begin
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_cyc_o <= 1'b1;
               end
               if (flush_i) begin
                  rd_buf_r <= 32'd0;
                  state_r  <= IDLE;
               end else if (wb.wb_ack_i || timeout_s) begin
                  if (timeout_s) begin
                     rd_buf_r  <= 32'd0;
                     bus_err_r <= 1'b1;
                  end else if (!wb.wb_we_o) begin
                     rd_buf_r <= wb.wb_dat_i;
                  end else begin
                     rd_buf_r <= rd_buf_r;
                  end
                  state_r <= (stall_i != 6'd0) ? WAIT_FOR_STALL : IDLE;
               end else begin
                  state_r <= BUSY;
               end
            end
            WAIT_FOR_STALL: begin
               if (flush_i) begin
                  rd_buf_r <= 32'd0;
                  state_r  <= IDLE;
               end else if (stall_i == 6'd0) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= WAIT_FOR_STALL;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Stall request and read-data return; ack data is forwarded in its own cycle.
   always_comb begin
      stallreq_s = 1'b0;
      cpu_data_s = 32'd0;
      if (rst) begin
         stallreq_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               stallreq_s = cpu_ce_i && !flush_i;
            end
            BUSY: begin
               if (flush_i) begin
                  stallreq_s = 1'b0;
               end else if (wb.wb_ack_i) begin
                  stallreq_s = 1'b0;
                  cpu_data_s = wb.wb_we_o ? 32'd0 : wb.wb_dat_i;
               end else begin
                  stallreq_s = 1'b1;
               end
            end
            WAIT_FOR_STALL: begin
               cpu_data_s = rd_buf_r;
            end
            default: begin
               stallreq_s = 1'b0;
            end
         endcase
      end
   end

   assign stallreq_o = stallreq_s;
   assign cpu_data_o = cpu_data_s;
   assign bus_err_o  = bus_err_r && !rst;

endmodule

// File: tb/tb_cpu_wb_bus_if.sv
// Directed self-checking bench for cpu_wb_bus_if (default and WB_TIMEOUT_EN builds).
module tb_cpu_wb_bus_if;
   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] rdata;
   logic        stallreq;
   logic        bus_err;
   int          tests;
   int          fails;

   cpu_wb_bus_if_if wb ();

   cpu_wb_bus_if dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall),
      .flush_i    (flush),
      .cpu_ce_i   (ce),
      .cpu_addr_i (addr),
      .cpu_data_i (wdata),
      .cpu_we_i   (we),
      .cpu_sel_i  (sel),
      .cpu_data_o (rdata),
      .stallreq_o (stallreq),
      .bus_err_o  (bus_err),
      .wb         (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; ce = 1'b1; addr = 32'h0000_0040; we = 1'b0; sel = 4'hF;
      tick; tick; #1;
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL rst_stallreq: got %0h expected 0", stallreq); end
      tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
      tests++; if ({wb.wb_stb_o, wb.wb_cyc_o, wb.wb_we_o} !== 3'b000) begin fails++; $display("FAIL rst_stb_cyc_we: got %b expected 000", {wb.wb_stb_o, wb.wb_cyc_o, wb.wb_we_o}); end
      tests++; if (wb.wb_adr_o !== 32'd0) begin fails++; $display("FAIL rst_adr: got %h expected 0", wb.wb_adr_o); end
      tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL rst_bus_err: got %0h expected 0", bus_err); end
      tick; rst = 1'b0; ce = 1'b0; #1;
   endtask

   task automatic test_read;
      tick; ce = 1'b1; addr = 32'h0000_0040; we = 1'b0; sel = 4'hF; #1;
      tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL read_req_stall: got %0h expected 1", stallreq); end
      for (int k = 1; k <= 3; k++) begin
         tick; ce = 1'b0;
         if (k == 3) begin wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h3401_1100; end
         #1;
         tests++; if ({wb.wb_stb_o, wb.wb_cyc_o} !== 2'b11) begin fails++; $display("FAIL read_stb_cyc c%0d: got %b expected 11", k, {wb.wb_stb_o, wb.wb_cyc_o}); end
         tests++; if (wb.wb_adr_o !== 32'h0000_0040) begin fails++; $display("FAIL read_adr c%0d: got %h expected 00000040", k, wb.wb_adr_o); end
         if (k < 3) begin
            tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL read_busy_stall c%0d: got %0h expected 1", k, stallreq); end
         end else begin
            tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL read_ack_stall: got %0h expected 0", stallreq); end
            tests++; if (rdata !== 32'h3401_1100) begin fails++; $display("FAIL read_ack_data: got %h expected 34011100", rdata); end
         end
      end
      tick; wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'd0; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_cyc_o} !== 2'b00) begin fails++; $display("FAIL read_done_stb: got %b expected 00", {wb.wb_stb_o, wb.wb_cyc_o}); end
      tests++; if (wb.wb_adr_o !== 32'd0) begin fails++; $display("FAIL read_done_adr: got %h expected 0", wb.wb_adr_o); end
      tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL read_idle_data: got %h expected 0", rdata); end
   endtask

   task automatic test_write;
      tick; ce = 1'b1; addr = 32'h0000_0100; wdata = 32'hDEAD_BEEF; we = 1'b1; sel = 4'hF; stall = 6'd1; #1;
      tick; ce = 1'b0; we = 1'b0; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hCAFE_F00D; #1;
      tests++; if (wb.wb_we_o !== 1'b1) begin fails++; $display("FAIL wr_we: got %0h expected 1", wb.wb_we_o); end
      tests++; if (wb.wb_dat_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_dat: got %h expected deadbeef", wb.wb_dat_o); end
      tests++; if ({wb.wb_adr_o, wb.wb_sel_o} !== {32'h0000_0100, 4'hF}) begin fails++; $display("FAIL wr_adr_sel: got %h/%h expected 00000100/f", wb.wb_adr_o, wb.wb_sel_o); end
      tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL wr_ack_data: got %h expected 0", rdata); end
      tick; wb.wb_ack_i = 1'b0; stall = 6'd0; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_we_o, wb.wb_dat_o} !== 34'd0) begin fails++; $display("FAIL wr_done_outputs: got %b/%b/%h expected 0/0/0", wb.wb_stb_o, wb.wb_we_o, wb.wb_dat_o); end
      tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL wr_buf_unchanged: got %h expected 0", rdata); end
      tick; #1;
   endtask

   task automatic test_stall_read;
      tick; ce = 1'b1; addr = 32'h0000_0080; we = 1'b0; #1;
      tick; ce = 1'b0; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h1234_5678; stall = 6'b000011; #1;
      tests++; if (rdata !== 32'h1234_5678) begin fails++; $display("FAIL stl_ack_data: got %h expected 12345678", rdata); end
      for (int k = 1; k <= 2; k++) begin
         tick; wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'd0;
         if (k == 2) stall = 6'd0;
         #1;
         tests++; if (rdata !== 32'h1234_5678) begin fails++; $display("FAIL stl_wait_data w%0d: got %h expected 12345678", k, rdata); end
         tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL stl_wait_stall w%0d: got %0h expected 0", k, stallreq); end
      end
      tick; #1;
      tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL stl_idle_data: got %h expected 0", rdata); end
   endtask

   task automatic test_flush;
      tick; ce = 1'b1; addr = 32'h0000_0300; we = 1'b0; #1;
      tick; ce = 1'b0; #1;
      tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL fl_busy_stall: got %0h expected 1", stallreq); end
      tick; wb.wb_ack_i = 1'b1; flush = 1'b1; wb.wb_dat_i = 32'hAAAA_5555; stall = 6'd1; #1;
      tests++; if ({stallreq, rdata} !== 33'd0) begin fails++; $display("FAIL fl_ack_cycle: got %0h/%h expected 0/0", stallreq, rdata); end
      tick; wb.wb_ack_i = 1'b0; flush = 1'b0; ce = 1'b1; addr = 32'h0000_0200; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_cyc_o} !== 2'b00) begin fails++; $display("FAIL fl_stb_drop: got %b expected 00", {wb.wb_stb_o, wb.wb_cyc_o}); end
      tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL fl_data: got %h expected 0", rdata); end
      tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL fl_back_in_idle: got %0h expected 1", stallreq); end
      tick; ce = 1'b0; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0BAD_F00D; stall = 6'd0; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_adr_o} !== {1'b1, 32'h0000_0200}) begin fails++; $display("FAIL fl_next_access: got %b/%h expected 1/00000200", wb.wb_stb_o, wb.wb_adr_o); end
      tests++; if (rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL fl_next_data: got %h expected 0badf00d", rdata); end
      tick; wb.wb_ack_i = 1'b0; #1;
   endtask

   task automatic test_reset_mid;
      tick; ce = 1'b1; addr = 32'h0000_0400; we = 1'b1; wdata = 32'h0000_0055; sel = 4'h3; #1;
      tick; ce = 1'b0; we = 1'b0; #1;
      tests++; if (wb.wb_stb_o !== 1'b1) begin fails++; $display("FAIL rm_busy_stb: got %0h expected 1", wb.wb_stb_o); end
      tick; rst = 1'b1; #1;
      tests++; if ({stallreq, rdata, bus_err} !== 34'd0) begin fails++; $display("FAIL rm_outputs_in_rst: got %0h/%h/%0h expected 0/0/0", stallreq, rdata, bus_err); end
      tick; rst = 1'b0; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_cyc_o, wb.wb_we_o, wb.wb_sel_o} !== 7'd0) begin fails++; $display("FAIL rm_ctrl_cleared: got %b expected 0", {wb.wb_stb_o, wb.wb_cyc_o, wb.wb_we_o, wb.wb_sel_o}); end
      tests++; if ({wb.wb_adr_o, wb.wb_dat_o} !== 64'd0) begin fails++; $display("FAIL rm_adr_dat: got %h/%h expected 0/0", wb.wb_adr_o, wb.wb_dat_o); end
      tick; ce = 1'b1; addr = 32'h0000_0404; #1;
      tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL rm_idle_accept: got %0h expected 1", stallreq); end
      tick; ce = 1'b0; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0000_0077; #1;
      tests++; if (rdata !== 32'h0000_0077) begin fails++; $display("FAIL rm_after_data: got %h expected 00000077", rdata); end
      tick; wb.wb_ack_i = 1'b0; #1;
   endtask

   task automatic test_back_to_back;
      tick; ce = 1'b1; addr = 32'h0000_0500; we = 1'b0; #1;
      tick; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h1111_1111; #1;
      tests++; if (rdata !== 32'h1111_1111) begin fails++; $display("FAIL b2b_first_data: got %h expected 11111111", rdata); end
      tick; wb.wb_ack_i = 1'b0; addr = 32'h0000_0504; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_cyc_o} !== 2'b00) begin fails++; $display("FAIL b2b_idle_gap: got %b expected 00", {wb.wb_stb_o, wb.wb_cyc_o}); end
      tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL b2b_gap_stall: got %0h expected 1", stallreq); end
      tick; ce = 1'b0; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h2222_2222; #1;
      tests++; if ({wb.wb_stb_o, wb.wb_cyc_o, wb.wb_adr_o} !== {2'b11, 32'h0000_0504}) begin fails++; $display("FAIL b2b_second: got %b/%h expected 11/00000504", {wb.wb_stb_o, wb.wb_cyc_o}, wb.wb_adr_o); end
      tests++; if (rdata !== 32'h2222_2222) begin fails++; $display("FAIL b2b_second_data: got %h expected 22222222", rdata); end
      tick; wb.wb_ack_i = 1'b0; #1;
   endtask

   task automatic test_timeout;
      int n;
      int err_seen;
      logic lost;
      n = 0; err_seen = 0; lost = 1'b0;
      tick; ce = 1'b1; addr = 32'h0000_0600; we = 1'b0; stall = 6'd0; #1;
`ifdef WB_TIMEOUT_EN
      lost = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick; ce = 1'b0; #1;
         if (!wb.wb_stb_o) begin lost = 1'b0; break; end
         if (bus_err) err_seen++;
         n++;
      end
      tests++; if (lost !== 1'b0) begin fails++; $display("FAIL to_bound: stb still high after %0d cycles, expected drop", n); end
      tests++; if (n != 255) begin fails++; $display("FAIL to_busy_len: got %0d expected 255", n); end
      tests++; if (err_seen != 0) begin fails++; $display("FAIL to_early_err: got %0d expected 0", err_seen); end
      tests++; if ({bus_err, rdata} !== {1'b1, 32'd0}) begin fails++; $display("FAIL to_err_pulse: got %0h/%h expected 1/0", bus_err, rdata); end
      tick; #1;
      tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL to_err_one_cycle: got %0h expected 0", bus_err); end
`else
      for (int i = 0; i < 300; i++) begin
         tick; ce = 1'b0; #1;
         if (!wb.wb_stb_o) lost = 1'b1;
         if (bus_err) err_seen++;
         n++;
      end
      tests++; if (lost !== 1'b0) begin fails++; $display("FAIL nto_stb_held: got drop within %0d cycles, expected none", n); end
      tests++; if (err_seen != 0) begin fails++; $display("FAIL nto_bus_err: got %0d pulses expected 0", err_seen); end
      tick; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0000_0666; #1;
      tests++; if (rdata !== 32'h0000_0666) begin fails++; $display("FAIL nto_late_ack: got %h expected 00000666", rdata); end
      tick; wb.wb_ack_i = 1'b0; #1;
      tests++; if (wb.wb_stb_o !== 1'b0) begin fails++; $display("FAIL nto_done: got %0h expected 0", wb.wb_stb_o); end
`endif
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; stall = 6'd0; flush = 1'b0; ce = 1'b0; addr = 32'd0;
      wdata = 32'd0; we = 1'b0; sel = 4'd0;
      wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'd0;
      test_reset;
      test_read;
      test_write;
      test_stall_read;
      test_flush;
      test_reset_mid;
      test_back_to_back;
      test_timeout;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
